alu_issue_arbiter: RTL and testbench

ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

---
 rtl/alu_issue_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_issue_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - round-robin issue arbiter from reservation-station entries to a single ALU
// Back-to-back grants of the same entry are suppressed by masking with last cycle's grant.
module alu_issue_arbiter #(
    parameter int RS_WIDTH = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic                              clear,
    input  logic [(2**RS_WIDTH)-1:0]          req_valid,
    input  logic [32*(2**RS_WIDTH)-1:0]       req_a,
    input  logic [32*(2**RS_WIDTH)-1:0]       req_b,
    input  logic [4*(2**RS_WIDTH)-1:0]        req_op,
    output logic [(2**RS_WIDTH)-1:0]          grant,
    output logic                              cal,
    output logic [31:0]                       a,
    output logic [31:0]                       b,
    output logic [3:0]                        alu_op,
    output logic [RS_WIDTH-1:0]               from_rs_index,
    output logic [15:0]                       issue_cnt
);

    localparam int N = 2**RS_WIDTH;

    typedef enum logic {ACTIVE = 1'b0, FLUSH = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [N-1:0]          grant_q, grant_d;
    logic                  cal_q, cal_d;
    logic [31:0]           a_q, a_d;
    logic [31:0]           b_q, b_d;
    logic [3:0]            op_q, op_d;
    logic [RS_WIDTH-1:0]   idx_q, idx_d;
    logic [RS_WIDTH-1:0]   ptr_q, ptr_d;
    logic [15:0]           cnt_q, cnt_d;

    logic [N-1:0]          eligible;
    logic                  win_found;
    logic [RS_WIDTH-1:0]   win_idx;
    logic [RS_WIDTH-1:0]   cand;

    // The grant register doubles as the mask of the entry issued last cycle.
    assign eligible = req_valid & ~grant_q;

    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 0; k < N; k++) begin
            cand = ptr_q + RS_WIDTH'(k);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ACTIVE;
            grant_q <= '0;
            cal_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            grant_q <= grant_d;
            cal_q   <= cal_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = FLUSH;
        end else if (state_q == FLUSH) begin
            state_d = ACTIVE;
        end
    end

    always_comb begin
        grant_d = '0;
        cal_d   = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (clear) begin
            ptr_d = '0;
        end else if (state_q == ACTIVE && win_found) begin
            grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
            cal_d   = 1'b1;
            a_d     = req_a[{win_idx, 5'd0} +: 32];
            b_d     = req_b[{win_idx, 5'd0} +: 32];
            op_d    = req_op[{win_idx, 2'd0} +: 4];
            idx_d   = win_idx;
            ptr_d   = win_idx + RS_WIDTH'(1);
            cnt_d   = cnt_q + 16'd1;
        end
    end

    assign grant         = grant_q;
    assign cal           = cal_q;
    assign a             = a_q;
    assign b             = b_q;
    assign alu_op        = op_q;
    assign from_rs_index = idx_q;
    assign issue_cnt     = cnt_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb/tb_alu_issue_arbiter.sv - directed self-checking bench for alu_issue_arbiter (N=4)
module tb_alu_issue_arbiter;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          rdy_in;
    logic          clear;
    logic [3:0]    req_valid;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic [15:0]   req_op;
    logic [3:0]    grant;
    logic          cal;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [3:0]    alu_op;
    logic [1:0]    from_rs_index;
    logic [15:0]   issue_cnt;

    int checks = 0;
    int failures = 0;

    alu_issue_arbiter #(.RS_WIDTH(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .grant(grant), .cal(cal), .a(a), .b(b), .alu_op(alu_op),
        .from_rs_index(from_rs_index), .issue_cnt(issue_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_entry(input int i, input logic [31:0] va, input logic [31:0] vb, input logic [3:0] vop);
        req_a[32*i +: 32] = va;
        req_b[32*i +: 32] = vb;
        req_op[4*i +: 4]  = vop;
    endtask

    task automatic do_reset();
        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        clear     = 1'b0;
        req_valid = 4'b0000;
        step();
        step();
        rst_in = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cal"}, {31'd0, cal}, 32'd0);
        check({tag, "_grant"}, {28'd0, grant}, 32'd0);
        check({tag, "_a"}, a, 32'd0);
        check({tag, "_b"}, b, 32'd0);
        check({tag, "_op"}, {28'd0, alu_op}, 32'd0);
        check({tag, "_idx"}, {30'd0, from_rs_index}, 32'd0);
        check({tag, "_cnt"}, {16'd0, issue_cnt}, 32'd0);
    endtask

    initial begin
        req_a = '0;
        req_b = '0;
        req_op = '0;
        for (int i = 0; i < 4; i++) set_entry(i, 32'h100 + i, 32'h200 + i, 4'(i + 8));

        // Reset values
        do_reset();
        check_all_zero("reset");

        // Single request on entry 2
        set_entry(2, 32'd5, 32'd7, 4'b0000);
        req_valid = 4'b0100;
        step();
        check("single_cal", {31'd0, cal}, 32'd1);
        check("single_a", a, 32'd5);
        check("single_b", b, 32'd7);
        check("single_op", {28'd0, alu_op}, 32'd0);
        check("single_idx", {30'd0, from_rs_index}, 32'd2);
        check("single_grant", {28'd0, grant}, 32'b0100);
        check("single_cnt", {16'd0, issue_cnt}, 32'd1);
        set_entry(2, 32'h102, 32'h202, 4'd10);

        // Round robin over all four entries
        do_reset();
        req_valid = 4'b1111;
        step(); check("rr_g0", {28'd0, grant}, 32'b0001);
        step(); check("rr_g1", {28'd0, grant}, 32'b0010);
        check("rr_a1", a, 32'h101);
        check("rr_op1", {28'd0, alu_op}, 32'd9);
        step(); check("rr_g2", {28'd0, grant}, 32'b0100);
        step(); check("rr_g3", {28'd0, grant}, 32'b1000);
        check("rr_idx3", {30'd0, from_rs_index}, 32'd3);
        step(); check("rr_g4", {28'd0, grant}, 32'b0001);
        check("rr_cnt", {16'd0, issue_cnt}, 32'd5);

        // Mask rule: a lone request is not granted on consecutive cycles
        do_reset();
        req_valid = 4'b0001;
        step(); check("mask_g0", {28'd0, grant}, 32'b0001); check("mask_c0", {31'd0, cal}, 32'd1);
        step(); check("mask_g1", {28'd0, grant}, 32'b0000); check("mask_c1", {31'd0, cal}, 32'd0);
        check("mask_a_hold", a, 32'h100);
        step(); check("mask_g2", {28'd0, grant}, 32'b0001); check("mask_c2", {31'd0, cal}, 32'd1);
        check("mask_cnt", {16'd0, issue_cnt}, 32'd2);

        // Flush: two idle cycles, then restart from entry 0
        do_reset();
        req_valid = 4'b1111;
        step(); step();
        check("fl_pre_grant", {28'd0, grant}, 32'b0010);
        clear = 1'b1;
        step(); clear = 1'b0;
        check("fl_c0", {31'd0, cal}, 32'd0); check("fl_g0", {28'd0, grant}, 32'd0);
        check("fl_cnt0", {16'd0, issue_cnt}, 32'd2);
        step();
        check("fl_c1", {31'd0, cal}, 32'd0); check("fl_g1", {28'd0, grant}, 32'd0);
        step();
        check("fl_g2", {28'd0, grant}, 32'b0001); check("fl_cnt2", {16'd0, issue_cnt}, 32'd3);

        // rdy_in low freezes state, including clear being ignored
        do_reset();
        req_valid = 4'b0010;
        step(); check("rdy_g0", {28'd0, grant}, 32'b0010);
        rdy_in = 1'b0;
        req_valid = 4'b1111;
        clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rdy_hold_g", {28'd0, grant}, 32'b0010);
            check("rdy_hold_c", {31'd0, cal}, 32'd1);
        end
        clear = 1'b0;
        check("rdy_hold_cnt", {16'd0, issue_cnt}, 32'd1);
        rdy_in = 1'b1;
        step(); check("rdy_resume_g", {28'd0, grant}, 32'b0100);
        check("rdy_resume_cnt", {16'd0, issue_cnt}, 32'd2);

        // Counter wrap and asynchronous reset mid-stream
        do_reset();
        req_valid = 4'b1111;
        repeat (65535) step();
        check("wrap_ffff", {16'd0, issue_cnt}, 32'h0000FFFF);
        step();
        check("wrap_0000", {16'd0, issue_cnt}, 32'h00000000);
        check("wrap_cal", {31'd0, cal}, 32'd1);
        rst_in = 1'b0;
        #1;
        check_all_zero("async_rst");
        step();
        rst_in = 1'b1;
        step();
        check("post_rst_g", {28'd0, grant}, 32'b0001);
        check("post_rst_cnt", {16'd0, issue_cnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
